watch_display_driver: RTL and testbench

Downstream display stage for the digital watch. Consumes the time digits, stopwatch minutes/seconds and alarm flag produced by the watch top. Drives a 4-digit multiplexed common-anode seven-segment display, colon point and a piezo buzzer. Runs on the fast system clock, not the 1 Hz watch tick, and owns all refresh, blink and tone timing.

---
 rtl/watch_disp_pkg.sv | 53 +++++
 rtl/bin2bcd60.sv | 38 +++
 rtl/watch_display_driver.sv | 200 ++++++++++++++++++++
 tb/tb_watch_display_driver.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/watch_disp_pkg.sv
// Shared display types, segment glyphs and the BCD-to-segment decoder.
package watch_disp_pkg;

  // Active-low glyphs, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Digit slot index, 0 = leftmost.
  typedef logic [1:0] digit_idx_t;

  // Everything captured at frame start so one frame never tears.
  typedef struct packed {
    logic [1:0] tens_hours;
    logic [3:0] units_hours;
    logic [2:0] tens_minutes;
    logic [3:0] units_minutes;
    logic [5:0] sw_min;
    logic [5:0] sw_sec;
    logic       disp_sel;
    logic       blink_en;
    digit_idx_t blink_digit;
  } frame_t;

  // 0..9 to glyph; anything larger is shown as a dash.
  function automatic logic [6:0] seg_decode(input logic [3:0] val);
    logic [6:0] seg;
    case (val)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/bin2bcd60.sv
// Combinational 6-bit binary to two BCD digits, with a 0..59 range flag.
module bin2bcd60 (
  input  logic [5:0] bin_i,
  output logic [3:0] tens_o,
  output logic [3:0] units_o,
  output logic       in_range_o
);

  logic [5:0] rem;

  // Subtract the largest multiple of ten; the remainder is the units digit.
  always_comb begin
    tens_o = 4'd0;
    rem    = bin_i;
    if (bin_i >= 6'd60) begin
      tens_o = 4'd6;
      rem    = bin_i - 6'd60;
    end else if (bin_i >= 6'd50) begin
      tens_o = 4'd5;
      rem    = bin_i - 6'd50;
    end else if (bin_i >= 6'd40) begin
      tens_o = 4'd4;
      rem    = bin_i - 6'd40;
    end else if (bin_i >= 6'd30) begin
      tens_o = 4'd3;
      rem    = bin_i - 6'd30;
    end else if (bin_i >= 6'd20) begin
      tens_o = 4'd2;
      rem    = bin_i - 6'd20;
    end else if (bin_i >= 6'd10) begin
      tens_o = 4'd1;
      rem    = bin_i - 6'd10;
    end
    units_o    = rem[3:0];
    in_range_o = (bin_i <= 6'd59);
  end

endmodule

// File: rtl/watch_display_driver.sv
// Multiplexed 4-digit seven-segment driver with blink, colon and buzzer tone.
module watch_display_driver
  import watch_disp_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned BLINK_DIV   = 25000000,
  parameter int unsigned TONE_DIV    = 12500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] tens_hours,
  input  logic [3:0] units_hours,
  input  logic [2:0] tens_minutes,
  input  logic [3:0] units_minutes,
  input  logic [5:0] stopwatch_min,
  input  logic [5:0] stopwatch_sec,
  input  logic       disp_sel,
  input  logic       blink_en,
  input  logic [1:0] blink_digit,
  input  logic       alarm_sound,
  output logic [3:0] an_n,
  output logic [6:0] seg_n,
  output logic       dp_n,
  output logic       buzzer
);

  localparam int unsigned REF_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int unsigned TONE_W  = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;

  localparam logic [REF_W-1:0]   REF_LAST   = REF_W'(REFRESH_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
  localparam logic [TONE_W-1:0]  TONE_LAST  = TONE_W'(TONE_DIV - 1);

  logic [REF_W-1:0]   ref_cnt_q, ref_cnt_d;
  logic               scan_tick;
  digit_idx_t         idx_q, idx_d;
  frame_t             live, snap_q, frame;

  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_phase_q, blink_phase_d;

  logic [TONE_W-1:0]  tone_cnt_q, tone_cnt_d;
  logic               tone_phase_q, tone_phase_d;

  logic [3:0]         an_q, an_d;
  logic [6:0]         seg_q, seg_d;
  logic               dp_q, dp_d;

  logic [3:0]         min_tens, min_units, sec_tens, sec_units;
  logic               min_ok, sec_ok;
  logic [3:0]         digit_val;
  logic               digit_ok;
  logic [6:0]         glyph;

  // Refresh divider and next digit index.
  always_comb begin
    scan_tick = (ref_cnt_q == REF_LAST);
    ref_cnt_d = scan_tick ? '0 : ref_cnt_q + REF_W'(1);
    idx_d     = idx_q + 2'd1;
  end

  // Frame source: while idx is 3 the next tick starts a frame, so digit 0
  // is decoded from the live values that are being captured on that edge.
  always_comb begin
    live.tens_hours    = tens_hours;
    live.units_hours   = units_hours;
    live.tens_minutes  = tens_minutes;
    live.units_minutes = units_minutes;
    live.sw_min        = stopwatch_min;
    live.sw_sec        = stopwatch_sec;
    live.disp_sel      = disp_sel;
    live.blink_en      = blink_en;
    live.blink_digit   = blink_digit;
    frame              = (idx_q == 2'd3) ? live : snap_q;
  end

  bin2bcd60 u_min_bcd (
    .bin_i      (frame.sw_min),
    .tens_o     (min_tens),
    .units_o    (min_units),
    .in_range_o (min_ok)
  );

  bin2bcd60 u_sec_bcd (
    .bin_i      (frame.sw_sec),
    .tens_o     (sec_tens),
    .units_o    (sec_units),
    .in_range_o (sec_ok)
  );

  // Pick the digit for the upcoming slot and decode it to a glyph.
  always_comb begin
    digit_val = '0;
    digit_ok  = 1'b1;
    if (frame.disp_sel) begin
      case (idx_d)
        2'd0:    begin digit_val = min_tens;  digit_ok = min_ok; end
        2'd1:    begin digit_val = min_units; digit_ok = min_ok; end
        2'd2:    begin digit_val = sec_tens;  digit_ok = sec_ok; end
        default: begin digit_val = sec_units; digit_ok = sec_ok; end
      endcase
    end else begin
      case (idx_d)
        2'd0:    digit_val = {2'b00, frame.tens_hours};
        2'd1:    digit_val = frame.units_hours;
        2'd2:    digit_val = {1'b0, frame.tens_minutes};
        default: digit_val = frame.units_minutes;
      endcase
    end
    glyph = digit_ok ? seg_decode(digit_val) : SEG_DASH;
  end

  // Next registered display outputs; blink and colon use the post-edge phase.
  always_comb begin
    an_d = ~(4'b1000 >> idx_d);
    if (frame.blink_en && (frame.blink_digit == idx_d) && blink_phase_d) begin
      seg_d = SEG_BLANK;
    end else begin
      seg_d = glyph;
    end
    dp_d = ~((idx_d == 2'd1) && (frame.disp_sel || !blink_phase_d));
  end

  // Scan counter, frame snapshot and registered display outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ref_cnt_q <= '0;
      idx_q     <= 2'd3;
      snap_q    <= '0;
      an_q      <= '1;
      seg_q     <= SEG_BLANK;
      dp_q      <= 1'b1;
    end else begin
      ref_cnt_q <= ref_cnt_d;
      if (scan_tick) begin
        idx_q <= idx_d;
        if (idx_q == 2'd3) begin
          snap_q <= live;
        end
        an_q  <= an_d;
        seg_q <= seg_d;
        dp_q  <= dp_d;
      end
    end
  end

  // Free-running blink divider.
  always_comb begin
    if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d   = '0;
      blink_phase_d = ~blink_phase_q;
    end else begin
      blink_cnt_d   = blink_cnt_q + BLINK_W'(1);
      blink_phase_d = blink_phase_q;
    end
  end

  // Blink phase state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  // Tone divider, held cleared while the alarm is silent.
  always_comb begin
    if (!alarm_sound) begin
      tone_cnt_d   = '0;
      tone_phase_d = 1'b0;
    end else if (tone_cnt_q == TONE_LAST) begin
      tone_cnt_d   = '0;
      tone_phase_d = ~tone_phase_q;
    end else begin
      tone_cnt_d   = tone_cnt_q + TONE_W'(1);
      tone_phase_d = tone_phase_q;
    end
  end

  // Tone phase state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tone_cnt_q   <= '0;
      tone_phase_q <= 1'b0;
    end else begin
      tone_cnt_q   <= tone_cnt_d;
      tone_phase_q <= tone_phase_d;
    end
  end

  assign an_n   = an_q;
  assign seg_n  = seg_q;
  assign dp_n   = dp_q;
  assign buzzer = tone_phase_q;

endmodule

// File: tb/tb_watch_display_driver.sv
// Scoreboard bench for watch_display_driver with a slot-level reference model.
module tb_watch_display_driver;

  localparam int unsigned RD = 4;
  localparam int unsigned BD = 64;
  localparam int unsigned TD = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] tens_hours;
  logic [3:0] units_hours;
  logic [2:0] tens_minutes;
  logic [3:0] units_minutes;
  logic [5:0] stopwatch_min;
  logic [5:0] stopwatch_sec;
  logic       disp_sel;
  logic       blink_en;
  logic [1:0] blink_digit;
  logic       alarm_sound;
  logic [3:0] an_n;
  logic [6:0] seg_n;
  logic       dp_n;
  logic       buzzer;

  watch_display_driver #(
    .REFRESH_DIV (RD),
    .BLINK_DIV   (BD),
    .TONE_DIV    (TD)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .tens_hours    (tens_hours),
    .units_hours   (units_hours),
    .tens_minutes  (tens_minutes),
    .units_minutes (units_minutes),
    .stopwatch_min (stopwatch_min),
    .stopwatch_sec (stopwatch_sec),
    .disp_sel      (disp_sel),
    .blink_en      (blink_en),
    .blink_digit   (blink_digit),
    .alarm_sound   (alarm_sound),
    .an_n          (an_n),
    .seg_n         (seg_n),
    .dp_n          (dp_n),
    .buzzer        (buzzer)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned edge_no;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
  } slot_t;

  slot_t       exp_q[$];
  slot_t       got_slot;
  int          total = 0;
  int          bad = 0;
  int unsigned edge_cnt = 0;
  int unsigned alarm_run = 0;
  int unsigned last_chg = 0;
  bit          scoring = 1'b0;
  bit          done = 1'b0;
  logic [3:0]  prev_an = 4'hF;
  logic [3:0]  cur_an = 4'hF;
  logic [6:0]  cur_seg = 7'h7F;
  logic        cur_dp = 1'b1;

  logic [6:0]  GLYPH [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                              7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  logic [3:0]  AN_SEQ [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at edge %0d", nm, act, exp, edge_cnt);
    end
  endtask

  function automatic logic [6:0] ref_glyph(input int unsigned v);
    if (v > 9) return 7'h3F;
    return GLYPH[v];
  endfunction

  // Posedges since reset release, and how long the alarm has been held high.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      edge_cnt  <= 0;
      alarm_run <= 0;
    end else begin
      edge_cnt  <= edge_cnt + 1;
      alarm_run <= alarm_sound ? alarm_run + 1 : 0;
    end
  end

  // Expected four slots of a frame starting at posedge e0, from current inputs.
  task automatic push_frame(input int unsigned e0);
    int unsigned d[4];
    int unsigned m, s;
    slot_t       sl;
    bit          ph;
    m = stopwatch_min;
    s = stopwatch_sec;
    if (disp_sel) begin
      d[0] = (m <= 59) ? m / 10 : 99;
      d[1] = (m <= 59) ? m % 10 : 99;
      d[2] = (s <= 59) ? s / 10 : 99;
      d[3] = (s <= 59) ? s % 10 : 99;
    end else begin
      d[0] = tens_hours;
      d[1] = units_hours;
      d[2] = tens_minutes;
      d[3] = units_minutes;
    end
    for (int i = 0; i < 4; i++) begin
      sl.edge_no = e0 + RD * i;
      ph         = ((sl.edge_no / BD) % 2) == 1;
      sl.an      = AN_SEQ[i];
      sl.seg     = (blink_en && (blink_digit == 2'(i)) && ph) ? 7'h7F : ref_glyph(d[i]);
      sl.dp      = !((i == 1) && (disp_sel || !ph));
      exp_q.push_back(sl);
    end
  endtask

  task automatic wait_edge(input int unsigned n);
    while (edge_cnt < n) @(negedge clk);
  endtask

  task automatic set_time(input int unsigned th, input int unsigned uh,
                          input int unsigned tm, input int unsigned um);
    disp_sel      = 1'b0;
    tens_hours    = 2'(th);
    units_hours   = 4'(uh);
    tens_minutes  = 3'(tm);
    units_minutes = 4'(um);
  endtask

  task automatic set_sw(input int unsigned m, input int unsigned s);
    disp_sel      = 1'b1;
    stopwatch_min = 6'(m);
    stopwatch_sec = 6'(s);
  endtask

  task automatic set_random();
    tens_hours    = 2'($urandom_range(0, 3));
    units_hours   = 4'($urandom_range(0, 15));
    tens_minutes  = 3'($urandom_range(0, 7));
    units_minutes = 4'($urandom_range(0, 15));
    stopwatch_min = 6'($urandom_range(0, 63));
    stopwatch_sec = 6'($urandom_range(0, 63));
    disp_sel      = 1'($urandom_range(0, 1));
    blink_en      = 1'($urandom_range(0, 1));
    blink_digit   = 2'($urandom_range(0, 3));
  endtask

  task automatic tear_random();
    units_minutes = 4'($urandom_range(0, 15));
    stopwatch_sec = 6'($urandom_range(0, 63));
    disp_sel      = 1'($urandom_range(0, 1));
    blink_digit   = 2'($urandom_range(0, 3));
  endtask

  task automatic drain();
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0) break;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout got=%0d slots pending want=0", exp_q.size());
      exp_q.delete();
    end
    scoring = 1'b0;
  endtask

  task automatic check_reset_vals();
    check("reset_an", an_n, 4'hF);
    check("reset_seg", seg_n, 7'h7F);
    check("reset_dp", dp_n, 1'b1);
    check("reset_buzzer", buzzer, 1'b0);
  endtask

  // Monitor: pops an expected slot whenever the anode pattern moves on.
  always @(negedge clk) begin
    if (!rst) begin
      cur_an   = 4'hF;
      cur_seg  = 7'h7F;
      cur_dp   = 1'b1;
      last_chg = 0;
    end else begin
      if (scoring) begin
        if (an_n !== prev_an) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL slot_unexpected got an_n=%b want no change", an_n);
          end else begin
            got_slot = exp_q.pop_front();
            check("slot_edge", edge_cnt, got_slot.edge_no);
            check("slot_an", an_n, got_slot.an);
            check("slot_seg", seg_n, got_slot.seg);
            check("slot_dp", dp_n, got_slot.dp);
            cur_an  = got_slot.an;
            cur_seg = got_slot.seg;
            cur_dp  = got_slot.dp;
          end
          last_chg = edge_cnt;
        end else begin
          check("hold_seg", seg_n, cur_seg);
          check("hold_dp", dp_n, cur_dp);
          if (exp_q.size() != 0 && edge_cnt > last_chg + RD + 2) begin
            total++;
            bad++;
            $display("FAIL slot_timeout got no scan for %0d edges want %0d", edge_cnt - last_chg, RD);
            last_chg = edge_cnt;
          end
        end
      end
      check("buzzer", buzzer, ((alarm_run / TD) % 2));
    end
    prev_an = an_n;
  end

  // Alarm stimulus: one 20-cycle pulse, then random on/off runs.
  initial begin
    alarm_sound = 1'b0;
    wait (rst === 1'b1);
    repeat (10) @(negedge clk);
    alarm_sound = 1'b1;
    repeat (20) @(negedge clk);
    alarm_sound = 1'b0;
    repeat (10) @(negedge clk);
    while (!done) begin
      repeat ($urandom_range(1, 30)) @(negedge clk);
      alarm_sound = ~alarm_sound;
    end
    alarm_sound = 1'b0;
  end

  // Main display stimulus.
  initial begin
    int unsigned e0;
    set_time(0, 0, 0, 0);
    stopwatch_min = '0;
    stopwatch_sec = '0;
    blink_en      = 1'b0;
    blink_digit   = '0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_vals();
    @(negedge clk);
    rst     = 1'b1;
    scoring = 1'b1;
    for (int f = 0; f < 30; f++) begin
      e0 = 16 * f + 4;
      wait_edge(e0 - 1);
      if (f == 0) set_time(0, 2, 0, 5);
      else if (f == 1) set_sw(7, 59);
      else if (f == 2) set_time(1, 2, 3, 4);
      else if (f == 3) ;
      else if (f == 4) begin
        set_time(2, 3, 5, 9);
        blink_en    = 1'b1;
        blink_digit = 2'd1;
      end else if (f < 12) ;
      else if (f == 12) begin
        set_sw(59, 63);
        blink_en = 1'b0;
      end else set_random();
      push_frame(e0);
      if (f == 2) begin
        wait_edge(e0 + 8);
        units_minutes = 4'd8;
      end else if (f > 12 && $urandom_range(0, 1) == 1) begin
        wait_edge(e0 + 8);
        tear_random();
      end
    end
    drain();
    @(negedge clk);
    #3;
    rst = 1'b0;
    #1;
    check_reset_vals();
    exp_q.delete();
    repeat (5) @(negedge clk);
    rst     = 1'b1;
    scoring = 1'b1;
    for (int f = 0; f < 4; f++) begin
      e0 = 16 * f + 4;
      wait_edge(e0 - 1);
      set_random();
      push_frame(e0);
    end
    drain();
    done = 1'b1;
    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=no finish want=finish");
    $fatal(1, "simulation time limit");
  end

endmodule
